// File: rtl/and_arb_pkg.sv
// Shared types and helpers for the AND-unit arbiter.
//   state_t  : arbiter FSM state (IDLE / EXEC / ACK)
//   NREQ_DEF : default requester count
//   WIDTH_DEF: default operand width
//   next_rr  : round-robin winner search starting at ptr, wrapping at nreq
`timescale 1ns/1ps
package and_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;
    localparam int NREQ_MAX  = 16;

    // Scans ptr, ptr+1, ..., nreq-1, 0, ... and returns the first set bit.
    // Only meaningful when req has at least one bit set below nreq.
    function automatic int next_rr(input logic [NREQ_MAX-1:0] req,
                                   input int ptr, input int nreq);
        int   win;
        int   idx;
        logic found;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ_MAX; k++) begin
            if (k < nreq) begin
                idx = ptr + k;
                if (idx >= nreq) idx = idx - nreq;
                if (!found && req[idx[3:0]]) begin
                    win   = idx;
                    found = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/and_unit_arbiter_and_unit.sv
// Shared bitwise AND resource.
//   a, b : operands (WIDTH bits)
//   out  : a & b, purely combinational
`timescale 1ns/1ps
module and_unit #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out
);

    assign out = a & b;

endmodule

// File: rtl/and_unit_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters onto one shared AND unit.
//   clk, rst_n : clock, async active-low reset
//   req        : per-requester request (4-phase with ack)
//   a_in, b_in : packed operands, requester i at [i*WIDTH +: WIDTH]
//   ack        : per-requester acknowledge, one-hot or zero
//   out        : registered result of the last completed transaction
//   out_valid  : one-cycle pulse when out/out_id update
//   out_id     : requester that owns out
//   busy       : FSM not in IDLE
`timescale 1ns/1ps
module and_unit_arbiter
    import and_arb_pkg::*;
#(
    parameter  int NREQ  = NREQ_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      out,
    output logic                  out_valid,
    output logic [IDW-1:0]        out_id,
    output logic                  busy
);

    state_t              state, state_nxt;
    logic [IDW-1:0]      ptr, id_r, winner;
    logic [WIDTH-1:0]    a_r, b_r, and_out;
    logic [NREQ_MAX-1:0] req_ext;
    logic [NREQ-1:0]     onehot;

    always_comb begin
        req_ext           = '0;
        req_ext[NREQ-1:0] = req;
    end

    assign winner = IDW'(next_rr(req_ext, int'(ptr), NREQ));

    always_comb begin
        onehot = '0;
        for (int i = 0; i < NREQ; i++) onehot[i] = (id_r == IDW'(i));
    end

    // Operands come from a_r/b_r, so the requester may change its inputs
    // once it has been sampled without affecting the result.
    and_unit #(.WIDTH(WIDTH)) u_and (
        .a   (a_r),
        .b   (b_r),
        .out (and_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = EXEC;
            EXEC:    state_nxt = ACK;
            ACK:     if (!req[id_r]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            id_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            ack       <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            out_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        a_r  <= a_in[int'(winner)*WIDTH +: WIDTH];
                        b_r  <= b_in[int'(winner)*WIDTH +: WIDTH];
                        id_r <= winner;
                        ptr  <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
                    end
                end
                EXEC: begin
                    out       <= and_out;
                    out_id    <= id_r;
                    out_valid <= 1'b1;
                    ack       <= onehot;
                end
                ACK: begin
                    out_valid <= 1'b0;
                    // An early-dropped req lands here already low, so ack
                    // is held for just this one cycle.
                    if (!req[id_r]) ack <= '0;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/and_unit_arbiter.md
Name: and_unit_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one WIDTH-bit bitwise AND unit between NREQ requesters.
- Each requester presents an operand pair and a 4-phase req/ack handshake.
- The block grants one requester at a time, latches its operands, computes a & b through the shared unit, and returns a registered result tagged with the requester id.
- Sits between requester blocks in the combinational test-circuit datapath and the single shared logic resource.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, operand/result width in bits.
- IDW, $clog2(NREQ), width of the requester id (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester request, held high until ack is seen.
- a_in  input  NREQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- b_in  input  NREQ*WIDTH  operand b; same packing as a_in.
- ack  output  NREQ  per-requester acknowledge, one-hot or zero.
- out  output  WIDTH  result of the last completed transaction, held until the next one.
- out_valid  output  1  one-cycle pulse when out/out_id update.
- out_id  output  IDW  id of the requester that owns out.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, ptr=0, ack=0, out=0, out_valid=0, out_id=0, busy=0, latched operands=0.
  - An in-flight transaction is dropped and never acknowledged.
- FSM states: IDLE, EXEC, ACK.
- IDLE:
  - If req != 0 at the clock edge: winner = first set req bit searching from ptr upward with wrap (ptr, ptr+1, ..., NREQ-1, 0, ...).
  - Latch a_r/b_r from the winner's slices and id_r=winner.
  - ptr <= (winner+1) mod NREQ; go to EXEC.
  - If req == 0: stay in IDLE.
- EXEC (exactly one cycle):
  - out <= a_r & b_r via the shared unit; out_id <= id_r; out_valid <= 1; ack[id_r] <= 1; go to ACK.
- ACK:
  - out_valid <= 0.
  - ack[id_r] stays high while req[id_r]=1.
  - When req[id_r]=0 at an edge: ack <= 0; go to IDLE.
- Latency: req sampled at edge E0 -> out/out_valid/ack high after edge E1 (2 edges).
  - Minimum transaction period is 3 cycles plus the requester's drop latency.
  - Back-to-back requests are never served in consecutive cycles.
- Operand isolation: changes on a_in/b_in after the IDLE sampling edge do not affect the result.
- Simultaneous requests:
  - Exactly one winner per arbitration.
  - Losers keep req high and are served in round-robin order.
  - A requester is never starved: it waits at most NREQ-1 transactions.
- Requests arriving during EXEC or ACK wait for IDLE.
- Early drop (req[id_r] falls before ack, a protocol violation):
  - The transaction still completes and out_valid pulses.
  - In ACK, req is already low, so ack clears and the FSM returns to IDLE on the next edge (ack high for one cycle).
- ptr wraps from NREQ-1 to 0.
- Result width equals WIDTH; there is no carry or extension.
- ack bits other than ack[id_r] are always 0.
- busy = (state != IDLE).

Decomposition:
- Package and_arb_pkg:
  - state typedef (enum IDLE/EXEC/ACK, 2 bits).
  - Default constants NREQ_DEF=4, WIDTH_DEF=8.
  - Function next_rr(req, ptr) returning the winner index.
- Sub-module and_unit:
  - Parameter WIDTH; ports a, b, out (combinational out = a & b).
  - This is the shared resource; exactly one instance lives inside the arbiter.

Test Plan:
- Reset mid-transaction: req[0]=1, deassert rst_n during EXEC -> ack=0, out=0, out_valid=0, busy=0 immediately (asynchronously); after release, req[0] is re-arbitrated from IDLE.
- Single request: req[0]=1, a0=8'hF0, b0=8'h3C -> after 2 edges out=8'h30, out_id=0, out_valid high exactly 1 cycle, ack[0] high until req[0] drops, then IDLE next edge.
- Fairness: req=4'b1111 with every requester re-raising req after its ack drops -> service order 0,1,2,3,0,1 with no repeats until all are served.
- Pointer wrap: serve requester 1 (ptr=2), then req=4'b1010 -> requester 3 served before 1; ptr returns to 0 then 2.
- Operands: req[2] with (a,b) = (00,FF), (FF,FF), (AA,55), (C3,81) -> out = 00, FF, 00, 81; changing a2 during EXEC leaves the result unchanged.
- Early drop: req[1] pulsed for 1 cycle only -> out_valid pulses, ack[1] high for one cycle, FSM returns to IDLE, and no second transaction for requester 1.
